// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The stream is: header byte N, 4N little-endian payload bytes, XOR checksum byte.
package imem_loader_pkg;

    localparam int DEF_DEPTH      = 64;
    localparam int DEF_ADDR_W     = 6;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = 2;
    localparam int HDR_W          = 8;
    localparam int CHK_W          = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream, memory-write and status signals of the boot loader.
// master = the loader itself, slave = the byte source / memory / core side.
interface imem_boot_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata,
        output cpu_hold, busy, done, error
    );

    modport slave (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata,
        input  cpu_hold, busy, done, error
    );

endinterface

// File: rtl/imem_word_packer.sv
// Collects little-endian bytes into 32-bit words; word_valid pulses for one
// cycle after the 4th byte of a word is accepted.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [BCNT_W-1:0]                   byte_cnt_reg;
    logic [BYTES_PER_WORD-2:0][7:0]      lane_reg;
    logic [BYTES_PER_WORD-2:0]           lane_hit;
    logic                                word_valid_reg;
    logic [31:0]                         word_data_reg;

    assign last_byte = (byte_cnt_reg == BCNT_W'(BYTES_PER_WORD - 1));

    // Lower lanes are parked until the top byte arrives and completes the word.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            assign lane_hit[gi] = byte_valid && (byte_cnt_reg == BCNT_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg   <= '0;
            lane_reg       <= '0;
            word_valid_reg <= 1'b0;
            word_data_reg  <= '0;
        end else begin
            word_valid_reg <= 1'b0;
            for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                if (lane_hit[i]) begin
                    lane_reg[i] <= byte_data;
                end
            end
            if (clear) begin
                byte_cnt_reg <= '0;
            end else if (byte_valid) begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
                if (last_byte) begin
                    word_valid_reg <= 1'b1;
                    word_data_reg  <= {byte_data, lane_reg};
                end
            end
        end
    end

    assign word_valid = word_valid_reg;
    assign word_data  = word_data_reg;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: programs instruction memory from a byte stream, checks the XOR
// checksum and releases the core (cpu_hold low) only after a clean load.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    imem_boot_loader_if.master bus
);

    state_t             state_reg;
    state_t             state_next;
    logic [HDR_W-1:0]   n_reg;
    logic [ADDR_W-1:0]  word_cnt_reg;
    logic [ADDR_W-1:0]  waddr_reg;
    logic [CHK_W-1:0]   xor_reg;

    logic               in_ready;
    logic               accept;
    logic               hdr_ok;
    logic               last_word;
    logic               last_byte;
    logic               word_valid;
    logic [31:0]        word_data;

    assign accept    = bus.in_valid && in_ready;
    assign hdr_ok    = (bus.in_data != '0) && (bus.in_data <= HDR_W'(DEPTH));
    assign last_word = (HDR_W'(word_cnt_reg) == (n_reg - HDR_W'(1)));

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_reg == HDR),
        .byte_valid (accept && (state_reg == DATA)),
        .byte_data  (bus.in_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.start) state_next = HDR;
            HDR:  if (accept) state_next = hdr_ok ? DATA : ERR;
            DATA: if (accept && last_byte && last_word) state_next = CHK;
            CHK:  if (accept) state_next = (bus.in_data == xor_reg) ? DONE : ERR;
            DONE: if (bus.start) state_next = HDR;
            ERR:  if (bus.start) state_next = HDR;
            default: state_next = IDLE;
        endcase
    end

    // The write address is captured with the 4th byte so it lines up with
    // the registered write pulse; the index stops at N-1 to avoid wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg        <= '0;
            word_cnt_reg <= '0;
            waddr_reg    <= '0;
            xor_reg      <= '0;
        end else if (accept) begin
            if (state_reg == HDR && hdr_ok) begin
                n_reg        <= bus.in_data;
                word_cnt_reg <= '0;
                xor_reg      <= '0;
            end else if (state_reg == DATA) begin
                xor_reg <= xor_reg ^ bus.in_data;
                if (last_byte) begin
                    waddr_reg <= word_cnt_reg;
                    if (!last_word) begin
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready     = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        bus.cpu_hold = 1'b1;
        case (state_reg)
            HDR, DATA, CHK: begin
                in_ready = 1'b1;
                bus.busy = 1'b1;
            end
            DONE: begin
                bus.done     = 1'b1;
                bus.cpu_hold = 1'b0;
            end
            ERR:     bus.error = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = word_valid;
    assign bus.imem_waddr = waddr_reg;
    assign bus.imem_wdata = word_data;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of load sessions plus hand-written reset
// sequences; expected memory writes go through a scoreboard queue.
module tb_imem_boot_loader;
    import imem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(DEF_ADDR_W)) bus ();

    imem_boot_loader #(.DEPTH(DEF_DEPTH), .ADDR_W(DEF_ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // src: 0 random words, 1 reference program, 2 single word 0x00000013
    typedef struct {
        logic [7:0] hdr;
        int         nwords;
        bit         bad_chk;
        int         gap;
        bit         mid_start;
        int         src;
        bit         exp_done;
        bit         exp_error;
        string      name;
    } rec_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          prev_we = 1'b0;
    logic [31:0] pool [4] = '{32'hFFC4A303, 32'h0064A423, 32'h0062E233, 32'hFE420AE3};
    rec_t        tbl [6];
    rec_t        one_word;

    // Write monitor: compare every imem_we pulse against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.imem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%08h required no write",
                         bus.imem_waddr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (e.addr !== bus.imem_waddr || e.data !== bus.imem_wdata) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%08h required addr=%0d data=%08h",
                             bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=%08h ok", bus.imem_waddr, bus.imem_wdata);
                end
            end
            if (prev_we) begin
                errors++;
                $display("FAIL we_back_to_back got 2 cycles required 1 cycle");
            end
        end
        prev_we = bus.imem_we;
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got 0 required 1 (byte %02h)", b);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_session(input rec_t r);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [31:0] word;
        logic [4:0]  got;
        logic [4:0]  want;
        chk = 8'h00;
        pulse_start();
        send_byte(r.hdr, r.gap);
        for (int w = 0; w < r.nwords; w++) begin
            if (r.src == 1)      word = pool[w % 4];
            else if (r.src == 2) word = 32'h00000013;
            else                 word = $urandom;
            for (int k = 0; k < 4; k++) begin
                b = word[8*k +: 8];
                chk = chk ^ b;
                if (k == 3) exp_q.push_back('{addr: DEF_ADDR_W'(w), data: word});
                send_byte(b, r.gap);
                if (r.mid_start && w == 1 && k == 1) pulse_start();
            end
        end
        if (r.nwords > 0) send_byte(r.bad_chk ? (chk ^ 8'h01) : chk, r.gap);
        repeat (2) @(negedge clk);
        got  = {bus.done, bus.error, bus.cpu_hold, bus.in_ready, bus.busy};
        want = {r.exp_done, r.exp_error, !r.exp_done, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL session_%s got done/err/hold/rdy/busy=%05b required %05b",
                     r.name, got, want);
        end else begin
            $display("session %s: done=%0b error=%0b cpu_hold=%0b ok",
                     r.name, bus.done, bus.error, bus.cpu_hold);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes_%s got %0d pending required 0", r.name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [5:0]  flags;
        logic [37:0] rgot;

        tbl[0] = '{8'h04,  4, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0, "good4"};
        tbl[1] = '{8'h04,  4, 1'b1, 0, 1'b0, 1, 1'b0, 1'b1, "bad_checksum"};
        tbl[2] = '{8'h00,  0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b1, "hdr_zero"};
        tbl[3] = '{8'h41,  0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b1, "hdr_65"};
        tbl[4] = '{8'h04,  4, 1'b0, 3, 1'b1, 1, 1'b1, 1'b0, "gap3_midstart"};
        tbl[5] = '{8'h40, 64, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, "full_depth"};
        one_word = '{8'h01, 1, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0, "one_word"};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle with a noisy byte source: nothing may move.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.in_data  = 8'($urandom);
            flags = {bus.cpu_hold, bus.in_ready, bus.imem_we, bus.done, bus.error, bus.busy};
            checks++;
            if (flags !== 6'b100000) begin
                errors++;
                $display("FAIL idle_cycle%0d got hold/rdy/we/done/err/busy=%06b required 100000",
                         i, flags);
            end else begin
                $display("idle cycle %0d ok", i);
            end
        end
        bus.in_valid = 1'b0;

        for (int t = 0; t < 6; t++) run_session(tbl[t]);

        // Asynchronous reset in the middle of the second word.
        pulse_start();
        send_byte(8'h04, 0);
        exp_q.push_back('{addr: DEF_ADDR_W'(0), data: pool[0]});
        for (int k = 0; k < 4; k++) send_byte(pool[0][8*k +: 8], 0);
        for (int k = 0; k < 2; k++) send_byte(pool[1][8*k +: 8], 0);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_rst got %0b required 1", bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        rgot = {bus.cpu_hold, bus.in_ready, bus.busy, bus.done, bus.error, bus.imem_we,
                bus.imem_wdata};
        checks++;
        if (rgot !== {6'b100000, 32'h0} || bus.imem_waddr !== '0) begin
            errors++;
            $display("FAIL async_rst got flags/wdata=%010h waddr=%0d required 2000000000 waddr=0",
                     rgot, bus.imem_waddr);
        end else begin
            $display("async reset mid-session ok");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pre_rst_write got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        rst = 1'b0;
        run_session(one_word);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
